// File: rtl/audio_clk_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// audio_clk_pkg : shared constants and index-width helper for audio_clk_gen
// Rev 1.0
// ---------------------------------------------------------------------------
package audio_clk_pkg;

  localparam int MODE_I2S    = 0;
  localparam int MODE_TDM_FS = 1;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_clk_prescaler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// audio_clk_prescaler : runtime-programmable 50% duty bit clock with strobes
// Rev 1.0
// ---------------------------------------------------------------------------
module audio_clk_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_clk,
  input  logic [DIV_W-1:0] div,
  output logic             bclk,
  output logic             bclk_rise,
  output logic             bclk_fall
);

  logic [DIV_W-1:0] hc_q, hc_d;
  logic [DIV_W-1:0] divq_q, divq_d;
  logic [DIV_W-1:0] w_div_eff;
  logic             bclk_q, bclk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  assign w_div_eff = (div == '0) ? DIV_W'(1) : div;

  // The divisor is only re-latched on a toggle, so a new div never cuts a half-period short.
  always_comb begin
    hc_d   = hc_q;
    divq_d = divq_q;
    bclk_d = bclk_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (en_clk) begin
      if (hc_q == divq_q - DIV_W'(1)) begin
        hc_d   = '0;
        divq_d = w_div_eff;
        bclk_d = ~bclk_q;
        rise_d = ~bclk_q;
        fall_d = bclk_q;
      end else begin
        hc_d = hc_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hc_q   <= '0;
      divq_q <= w_div_eff;
      bclk_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      hc_q   <= hc_d;
      divq_q <= divq_d;
      bclk_q <= bclk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bclk      = bclk_q;
  assign bclk_rise = rise_q;
  assign bclk_fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/audio_clk_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// audio_clk_gen : bit clock, I2S/TDM frame clock, slot/bit counters, strobes
// Rev 1.0
// ---------------------------------------------------------------------------
module audio_clk_gen
  import audio_clk_pkg::*;
#(
  parameter int DIV_W         = 8,
  parameter int BITS_PER_SLOT = 32,
  parameter int SLOTS         = 2,
  parameter int MODE          = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en_clk,
  input  logic [DIV_W-1:0]                 div,
  output logic                             bclk,
  output logic                             bclk_rise,
  output logic                             bclk_fall,
  output logic                             lrclk,
  output logic [idx_w(SLOTS)-1:0]          slot_idx,
  output logic [idx_w(BITS_PER_SLOT)-1:0]  bit_idx,
  output logic                             frame_start
);

  localparam int              SW        = idx_w(SLOTS);
  localparam int              BW        = idx_w(BITS_PER_SLOT);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(BITS_PER_SLOT - 1);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SLOTS - 1);

  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          lr_q, lr_d;
  logic          w_last_bit;
  logic          w_lr_next;

  audio_clk_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .en_clk    (en_clk),
    .div       (div),
    .bclk      (bclk),
    .bclk_rise (bclk_rise),
    .bclk_fall (bclk_fall)
  );

  always_comb begin
    bit_d  = bit_q;
    slot_d = slot_q;
    if (bclk_fall) begin
      if (bit_q == BIT_LAST) begin
        bit_d  = '0;
        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
      end else begin
        bit_d = bit_q + BW'(1);
      end
    end
  end

  assign w_last_bit = (bit_d == BIT_LAST);

  generate
    if (MODE == MODE_I2S) begin : g_i2s
      logic [SW-1:0] w_slot_after;
      assign w_slot_after = (slot_d == SLOT_LAST) ? '0 : slot_d + SW'(1);
      // Word select switches one bit early so it leads the slot boundary.
      assign w_lr_next = w_last_bit ? w_slot_after[0] : lr_q;
    end else begin : g_tdm
      assign w_lr_next = w_last_bit && (slot_d == SLOT_LAST);
    end
  endgenerate

  assign lr_d = bclk_fall ? w_lr_next : lr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_q  <= '0;
      slot_q <= '0;
      lr_q   <= 1'b0;
    end else begin
      bit_q  <= bit_d;
      slot_q <= slot_d;
      lr_q   <= lr_d;
    end
  end

  assign lrclk       = lr_q;
  assign slot_idx    = slot_q;
  assign bit_idx     = bit_q;
  assign frame_start = bclk_rise && (bit_q == '0) && (slot_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_audio_clk_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_audio_clk_gen : randomized bench for I2S and TDM instances against a
// fall-counting reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_audio_clk_gen;

  localparam int B0 = 32, S0 = 2, N0 = B0 * S0;
  localparam int B1 = 16, S1 = 4, N1 = B1 * S1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en_clk = 1'b1;
  logic [7:0] div = 8'd2;

  logic       bclk0, rise0, fall0, lr0, fs0;
  logic [0:0] slot0;
  logic [4:0] bit0;
  logic       bclk1, rise1, fall1, lr1, fs1;
  logic [1:0] slot1;
  logic [3:0] bit1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_clk_gen #(.DIV_W(8), .BITS_PER_SLOT(B0), .SLOTS(S0), .MODE(0)) u_i2s (
    .clk(clk), .reset(reset), .en_clk(en_clk), .div(div),
    .bclk(bclk0), .bclk_rise(rise0), .bclk_fall(fall0), .lrclk(lr0),
    .slot_idx(slot0), .bit_idx(bit0), .frame_start(fs0)
  );

  audio_clk_gen #(.DIV_W(8), .BITS_PER_SLOT(B1), .SLOTS(S1), .MODE(1)) u_tdm (
    .clk(clk), .reset(reset), .en_clk(en_clk), .div(div),
    .bclk(bclk1), .bclk_rise(rise1), .bclk_fall(fall1), .lrclk(lr1),
    .slot_idx(slot1), .bit_idx(bit1), .frame_start(fs1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: bclk as a sequence of half-periods, counters as "falls seen so far".
  logic m_bclk, m_rise, m_fall;
  int   m_rem;
  int   m_falls;
  bit   m_valid = 1'b0;

  function automatic int eff_div(input logic [7:0] d);
    return (d == 8'd0) ? 1 : int'(d);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_bclk  <= 1'b0;
      m_rise  <= 1'b0;
      m_fall  <= 1'b0;
      m_rem   <= eff_div(div);
      m_falls <= 0;
      m_valid <= 1'b1;
    end else begin
      if (m_fall) m_falls <= m_falls + 1;
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      if (en_clk) begin
        if (m_rem == 1) begin
          m_bclk <= !m_bclk;
          m_rise <= !m_bclk;
          m_fall <= m_bclk;
          m_rem  <= eff_div(div);
        end else begin
          m_rem <= m_rem - 1;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int p0, p1;
    if (m_valid) begin
      p0 = m_falls % N0;
      p1 = m_falls % N1;
      chk("i2s_bclk",  bclk0, m_bclk);
      chk("i2s_rise",  rise0, m_rise);
      chk("i2s_fall",  fall0, m_fall);
      chk("i2s_bit",   bit0,  p0 % B0);
      chk("i2s_slot",  slot0, p0 / B0);
      chk("i2s_lrclk", lr0,   (((p0 + 1) % N0) / B0) % 2);
      chk("i2s_fs",    fs0,   m_rise && (p0 == 0));
      chk("tdm_bclk",  bclk1, m_bclk);
      chk("tdm_rise",  rise1, m_rise);
      chk("tdm_fall",  fall1, m_fall);
      chk("tdm_bit",   bit1,  p1 % B1);
      chk("tdm_slot",  slot1, p1 / B1);
      chk("tdm_lrclk", lr1,   p1 == N1 - 1);
      chk("tdm_fs",    fs1,   m_rise && (p1 == 0));
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Negedges until the chosen strobe shows, bounded.
  task automatic count_to(input bit want_rise, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_rise ? rise0 : fall0) && n < 60);
    if (n >= 60) chk("strobe_timeout", 0, 1);
  endtask

  initial begin : stim
    int n, t0, t_hi, hi_len, lr_slot, lr_bit, up_b, up_s, dn_b, dn_s;
    bit prev, seen_up, seen_dn, found;

    // Reset held with enable high: everything zero.
    reset = 1'b0; en_clk = 1'b1; div = 8'd2;
    repeat (5) @(negedge clk);
    chk("rst_bclk", bclk0, 0);
    chk("rst_lr",   lr0,   0);
    chk("rst_slot", slot0, 0);
    chk("rst_bit",  bit0,  0);
    reset = 1'b1;
    @(negedge clk); chk("rel_c1_rise", rise0, 0);
    @(negedge clk); chk("rel_rise", rise0, 1); chk("rel_fs", fs0, 1);
    t0 = cyc;
    @(negedge clk); chk("rel_c3_fall", fall0, 0);
    @(negedge clk); chk("rel_fall", fall0, 1);

    // I2S word select position and frame period.
    seen_up = 0; seen_dn = 0; found = 0; prev = lr0;
    up_b = 0; up_s = 0; dn_b = 0; dn_s = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (lr0 && !prev && !seen_up) begin seen_up = 1; up_b = bit0; up_s = slot0; end
      if (!lr0 && prev && !seen_dn) begin seen_dn = 1; dn_b = bit0; dn_s = slot0; end
      prev = lr0;
      if (fs0) found = 1;
    end
    chk("i2s_fs_found", found, 1);
    chk("i2s_fs_period", cyc - t0, 256);
    chk("i2s_lr_up_bit", up_b, 31); chk("i2s_lr_up_slot", up_s, 0);
    chk("i2s_lr_dn_bit", dn_b, 31); chk("i2s_lr_dn_slot", dn_s, 1);

    // TDM frame sync: two clocks high once per 128.
    div = 8'd1; do_reset();
    found = 0; lr_slot = 0; lr_bit = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (lr1) found = 1;
    end
    chk("tdm_lr_found", found, 1);
    t_hi = cyc; lr_slot = slot1; lr_bit = bit1;
    hi_len = 0;
    for (int i = 0; i < 10 && lr1; i++) begin hi_len++; @(negedge clk); end
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (lr1) found = 1;
    end
    chk("tdm_lr_len", hi_len, 2);
    chk("tdm_lr_period", cyc - t_hi, 128);
    chk("tdm_lr_slot", lr_slot, 3);
    chk("tdm_lr_bit", lr_bit, 15);

    // Runtime divisor change lands only at a bclk edge.
    div = 8'd2; do_reset();
    count_to(1'b1, n);
    div = 8'd5;
    count_to(1'b0, n); chk("hp_keep_2", n, 2);
    count_to(1'b1, n); chk("hp_new_5", n, 5);
    div = 8'd0;
    count_to(1'b0, n); chk("hp_still_5", n, 5);
    count_to(1'b1, n); chk("div0_hp_a", n, 1);
    count_to(1'b0, n); chk("div0_hp_b", n, 1);

    // Enable gating with bclk high and one cycle left in the half-period.
    div = 8'd2; do_reset();
    count_to(1'b1, n);
    @(negedge clk);
    en_clk = 1'b0;
    repeat (10) @(negedge clk);
    chk("gate_bclk", bclk0, 1);
    chk("gate_fall", fall0, 0);
    en_clk = 1'b1;
    @(negedge clk); chk("ungate_fall", fall0, 1);

    // Reset abandons a frame mid-way.
    div = 8'd1; do_reset();
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (slot0 == 1'd1 && bit0 == 5'd17) found = 1;
    end
    chk("mid_found", found, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_bclk", bclk0, 0); chk("mid_rst_slot", slot0, 0);
    chk("mid_rst_bit", bit0, 0);   chk("mid_rst_lr", lr0, 0);
    reset = 1'b1;
    count_to(1'b1, n);
    chk("mid_first_slot", slot0, 0); chk("mid_first_bit", bit0, 0);
    chk("mid_first_fs", fs0, 1);

    // Random divisor, enable and reset traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) div = 8'($urandom_range(0, 4));
      en_clk = ($urandom_range(0, 7) != 0);
      reset  = ($urandom_range(0, 399) != 0);
    end
    reset = 1'b1; en_clk = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_clk_gen.md
Name: audio_clk_gen

Overview:
- Parametrised successor to the DivFreq bit-clock divider in the PCM audio/microphone path.
- Generates a runtime-programmable serial bit clock (bclk) from the system clock, plus a frame/word clock (lrclk) in I2S or TDM frame-sync mode.
- Provides edge strobes and slot/bit counters, so the serialiser and deserialiser blocks work on clk with single-cycle enables instead of sampling bclk.

Parameters:
- DIV_W, 8, width of runtime half-period input div.
- BITS_PER_SLOT, 32, bclk periods per slot (≥2).
- SLOTS, 2, slots per frame (≥2); 2 = stereo I2S, >2 = TDM.
- MODE, 0, 0 = I2S lrclk (one-bit lead, odd slots high); 1 = TDM frame-sync pulse.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- en_clk  in  1  run enable; 0 freezes the generator.
- div  in  DIV_W  bclk half-period in clk cycles; 0 is treated as 1.
- bclk  out  1  bit clock, registered.
- bclk_rise  out  1  one-clk strobe, high in the cycle bclk becomes 1.
- bclk_fall  out  1  one-clk strobe, high in the cycle bclk becomes 0.
- lrclk  out  1  word-select / frame-sync, registered.
- slot_idx  out  $clog2(SLOTS)  current slot.
- bit_idx  out  $clog2(BITS_PER_SLOT)  current bit in slot, 0 = MSB.
- frame_start  out  1  strobe, equals bclk_rise for slot 0 bit 0.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Next cycle: bclk=0, lrclk=0, all strobes 0, slot_idx=0, bit_idx=0.
  - Internal half-period counter hc=0; latched divisor divq = max(div,1) sampled at that edge.
  - Reset dominates en_clk.
  - Reset mid-frame abandons the frame with no completion strobe.
- Half-period counter, when en_clk=1:
  - If hc==divq-1: hc<=0, bclk toggles, divq<=max(div,1).
  - Otherwise hc<=hc+1.
  - A new div value therefore takes effect only at a bclk edge; no runt pulses.
  - bclk period = 2*divq clk cycles; duty is exactly 50%.
- Strobes:
  - bclk_rise and bclk_fall are registered alongside bclk, so each strobe is high in the same cycle bclk shows its new level.
  - Strobes are never both high, and are 0 whenever en_clk=0.
- Counters (advance only on a fall, i.e. the cycle bclk goes 1→0 at the register):
  - bit_idx<=bit_idx+1; at BITS_PER_SLOT-1 it wraps to 0 and slot_idx increments.
  - slot_idx wraps from SLOTS-1 to 0.
  - After reset, the first bclk rising edge is bit 0 of slot 0, so frame_start fires on the first bclk_rise.
- lrclk, MODE 0:
  - Updated on fall.
  - lrclk <= odd(next slot) when the next bit_idx is BITS_PER_SLOT-1; otherwise unchanged.
  - Net effect: lrclk leads the slot boundary by one bit, as in I2S.
- lrclk, MODE 1:
  - lrclk=1 for exactly the bclk period of slot SLOTS-1, bit BITS_PER_SLOT-1.
  - Set on the fall entering that bit, cleared on the fall leaving it.
- en_clk=0: hc, bclk, lrclk, slot_idx and bit_idx hold their values; strobes are 0. Re-enabling resumes mid-period with no phase loss.
- div=0 behaves identically to div=1; bclk = clk/2.

Decomposition:
- Package audio_clk_pkg holds:
  - MODE_I2S=0 and MODE_TDM_FS=1 constants.
  - A slot/bit index width helper.
- Sub-module audio_clk_prescaler holds:
  - hc, divq, bclk and both strobes.
  - Its ports: clk, reset, en_clk, div, bclk, bclk_rise, bclk_fall.
- The top level holds bit/slot counters, lrclk and frame_start.

Test Plan:
- Reset/default:
  - Hold reset=0 5 cycles with en_clk=1 → all outputs 0.
  - Release with div=2 → bclk_rise in the 2nd cycle after release, bclk_fall in the 4th; period 4 clk.
  - frame_start coincides with the first rise.
- I2S frame (MODE 0, div=2, 32×2):
  - lrclk rises on the fall starting slot 0 bit 31 (bclk period 31).
  - lrclk falls at bclk period 63.
  - frame_start recurs every 256 clk.
- TDM (MODE 1, SLOTS=4, BITS_PER_SLOT=16, div=1):
  - lrclk high for exactly 2 clk once per 128 clk, during slot 3 bit 15.
- Runtime div change:
  - Change div 2→5 mid-half-period → the current half-period completes at 2; next half-periods are 5.
  - div=0 → period 2.
- en_clk gating:
  - Drop en_clk for 10 cycles at hc=1 with bclk=1 → outputs frozen, strobes 0.
  - On re-enable, bclk falls after 1 more cycle (div=2).
- Reset mid-frame:
  - Assert reset at slot 1 bit 17 → next cycle all outputs 0.
  - After release, the first rise is slot 0 bit 0 with frame_start=1.
